// File: rtl/div_seq.sv
// div_seq: multi-cycle radix-2 restoring divider sequencer for the execute
// stage. It accepts one DIV/DIVU at a time and returns {remainder, quotient}
// for the HI/LO write.
// Optional feature macro: DIV_FAST_SMALL_EN. When it is defined, a request
// whose dividend magnitude is below its divisor magnitude finishes at the
// acceptance edge.
module div_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  typedef enum logic [1:0] {S_FREE, S_BYZERO, S_ON, S_END} state_t;

  state_t      r_state, w_next;
  logic [4:0]  r_cnt;
  logic [64:0] r_work;     // {rem[64:32], quo[31:0]}
  logic [31:0] r_dvs;      // divisor magnitude
  logic        r_sgn1, r_sgn2, r_signed;
  logic [63:0] r_result;
  logic        r_ready;

  logic        w_accept;
  logic        w_small;
  logic [31:0] w_mag1, w_mag2;
  logic [64:0] w_shift, w_iter;
  logic [33:0] w_diff;
  logic [31:0] w_quo_fix, w_rem_fix;

  // Operand magnitudes: negate only signed operands with the sign bit set.
  assign w_mag1 = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
  assign w_mag2 = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;

  assign w_accept = start_i && !annul_i;

`ifdef DIV_FAST_SMALL_EN
  assign w_small = (w_mag1 < w_mag2);
`else
  assign w_small = 1'b0;
`endif

  // One restoring step. The remainder never exceeds 32 bits, so a 34-bit
  // difference is enough to read the borrow from bit 33.
  assign w_shift = r_work << 1;
  assign w_diff  = {1'b0, w_shift[64:32]} - {2'b00, r_dvs};
  assign w_iter  = w_diff[33] ? w_shift : {w_diff[32:0], w_shift[31:1], 1'b1};

  // Quotient sign follows XOR of the operand signs. Remainder sign follows the dividend.
  assign w_quo_fix = (r_signed && (r_sgn1 ^ r_sgn2)) ? (~w_iter[31:0] + 32'd1) : w_iter[31:0];
  assign w_rem_fix = (r_signed && r_sgn1) ? (~w_iter[63:32] + 32'd1) : w_iter[63:32];

  // State register
  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_FREE;
    else      r_state <= w_next;
  end

  // Next-state logic: annul aborts ON/BYZERO only, and END waits for start to drop
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FREE: begin
        if (w_accept) begin
          if (opdata2_i == 32'd0) w_next = S_BYZERO;
          else if (w_small)       w_next = S_END;
          else                    w_next = S_ON;
        end
      end
      S_BYZERO: w_next = annul_i ? S_FREE : S_END;
      S_ON: begin
        if (annul_i)             w_next = S_FREE;
        else if (r_cnt == 5'd31) w_next = S_END;
      end
      S_END:   if (!start_i) w_next = S_FREE;
      default: w_next = S_FREE;
    endcase
  end

  // Datapath: operand latch, iteration, and the registered result and ready outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt    <= 5'd0;
      r_work   <= 65'd0;
      r_dvs    <= 32'd0;
      r_sgn1   <= 1'b0;
      r_sgn2   <= 1'b0;
      r_signed <= 1'b0;
      r_result <= 64'd0;
      r_ready  <= 1'b0;
    end else begin
      case (r_state)
        S_FREE: begin
          r_result <= 64'd0;
          r_ready  <= 1'b0;
          if (w_accept && opdata2_i != 32'd0) begin
            r_dvs    <= w_mag2;
            r_work   <= {33'd0, w_mag1};
            r_sgn1   <= opdata1_i[31];
            r_sgn2   <= opdata2_i[31];
            r_signed <= signed_div_i;
            r_cnt    <= 5'd0;
            if (w_small) begin
              r_result <= {opdata1_i, 32'd0};
              r_ready  <= 1'b1;
            end
          end
        end
        S_BYZERO: begin
          r_result <= 64'd0;
          r_ready  <= !annul_i;
        end
        S_ON: begin
          if (annul_i) begin
            r_result <= 64'd0;
            r_ready  <= 1'b0;
          end else begin
            r_work <= w_iter;
            r_cnt  <= r_cnt + 5'd1;
            if (r_cnt == 5'd31) begin
              r_result <= {w_rem_fix, w_quo_fix};
              r_ready  <= 1'b1;
            end
          end
        end
        S_END: begin
          if (!start_i) begin
            r_result <= 64'd0;
            r_ready  <= 1'b0;
          end
        end
        default: begin
          r_result <= 64'd0;
          r_ready  <= 1'b0;
        end
      endcase
    end
  end

  assign result_o = r_result;
  assign ready_o  = r_ready;

endmodule

// File: doc/div_seq.md
# div_seq

Multi-cycle sequencer for the integer divider that the execute stage drives through its divide request interface (operands, signedness, start, and a 64-bit result with a ready flag). It accepts one DIV/DIVU request at a time and runs a 32-iteration radix-2 restoring division. It returns remainder and quotient packed for the HI/LO write. While busy, the execute stage holds `start_i` high and stalls on `ready_o` low.

## Interface
- No parameters; data width fixed at 32 (`RegBus`), result width 64 (`DoubleRegBus`).
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  synchronous reset, active-low (0 = reset).
- `signed_div_i`  in  1  1 = signed (DIV), 0 = unsigned (DIVU).
- `opdata1_i`  in  32  dividend.
- `opdata2_i`  in  32  divisor.
- `start_i`  in  1  request; held high by requester until it has consumed `ready_o`.
- `annul_i`  in  1  abort current request (pipeline flush).
- `result_o`  out  64  {remainder[63:32], quotient[31:0]}.
- `ready_o`  out  1  result valid.

## Operation
- States: FREE, BYZERO, ON, END. Reset (rst=0 at edge) → FREE, `result_o`=0, `ready_o`=0, iteration counter=0, working register=0.
- FREE: `ready_o`=0, `result_o`=0.
  - If `start_i`=1 and `annul_i`=0:
    - divisor=0 → BYZERO.
    - Otherwise latch magnitudes, original sign bits and `signed_div_i` → ON with counter=0.
  - Magnitude = two's-complement negate if signed and bit 31 set, else raw value.
- BYZERO: at the next edge → END with `result_o`=0 and `ready_o`=1.
- ON: one iteration per cycle on 65-bit working register {rem[64:32], quo[31:0]}.
  - Shift left 1.
  - Trial-subtract the divisor magnitude from the upper 33 bits. If the result is non-negative, write it back and set the quotient LSB; otherwise keep the shifted value and leave the LSB 0.
  - Counter increments. At the edge where counter=31, → END.
  - At that same edge, register `result_o` with the sign fixup applied and set `ready_o`=1.
- Sign fixup (signed only):
  - Quotient is negated iff the dividend and divisor signs differ.
  - Remainder is negated iff the dividend is negative.
  - Unsigned requests: no fixup.
- Overflow case 0x80000000 / 0xFFFFFFFF signed yields quotient 0x80000000, remainder 0. It is not trapped.
- END: `result_o` and `ready_o`=1 held while `start_i`=1. On an edge with `start_i`=0 → FREE, with `ready_o`=0 and `result_o`=0.
- Annul:
  - `annul_i`=1 in ON or BYZERO → FREE at the next edge, `ready_o` stays 0.
  - `annul_i`=1 in FREE blocks acceptance.
  - `annul_i` is ignored in END.
- `start_i` dropping in ON/BYZERO is ignored; only `annul_i` aborts.
- Reset has priority over all events, including mid-ON.

## Timing
- Start accepted at edge E0 (FREE → ON). Iterations run at E1..E32. `ready_o` and `result_o` become valid after E32: 32 cycles of stall in the requester.
- Divide-by-zero: `ready_o` valid after E1.
- Back-to-back requests need at least one cycle with `start_i`=0 (END → FREE) before the next acceptance edge. Minimum issue interval is 34 cycles.
- Operands are sampled only at E0; input changes during ON have no effect.
- Outputs are registered; no combinational path from inputs to outputs.

## Configuration
- `DIV_FAST_SMALL_EN` defined: in FREE, if divisor≠0 and dividend magnitude < divisor magnitude (unsigned compare), the request goes directly to END at E0.
  - Quotient=0, remainder=`opdata1_i` unmodified, `ready_o` valid after E0.
  - Divide-by-zero detection keeps priority.
- Not defined: every non-zero-divisor request takes the full 32 iterations.
- Results are identical either way; only latency differs.

## Test plan
- Unsigned 100 / 7, start held → `ready_o` rises exactly 32 cycles after acceptance, `result_o`={0x00000002, 0x0000000E}; drop start → `ready_o`=0, `result_o`=0 next cycle.
- Signed 0xFFFFFFF9 (−7) / 2 → `result_o`={0xFFFFFFFF, 0xFFFFFFFD}. Signed 7 / 0xFFFFFFFE (−2) → {0x00000001, 0xFFFFFFFD}.
- Divisor 0, either signedness → `ready_o` after one cycle in BYZERO, `result_o`=0.
- Assert `annul_i` in the 10th ON cycle → FREE, `ready_o` never asserts. A following 0xFFFFFFFF / 0x10 DIVU → {0x0000000F, 0x0FFFFFFF} after 32 cycles.
- Signed 0x80000000 / 0xFFFFFFFF → {0x00000000, 0x80000000}. Reset (rst=0) during ON cycle 20 → all outputs 0 and state FREE at the next edge.
- With `DIV_FAST_SMALL_EN`: unsigned 3 / 9 → `ready_o` after the acceptance edge, {0x00000003, 0}. Without the macro, the same request takes 32 cycles with the same result.
